wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 127 ++++++++++++
 tb/tb_wb_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: load formatting, result select, register-file write port, retire counter
module wb_stage #(
    // Reset value of the retire counter; zero except for counter bring-up.
    parameter logic [63:0] INSTRET_INIT = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic [4:0]  in_rd,
    input  logic        in_reg_write,
    input  logic [1:0]  mem_to_reg,
    input  logic [2:0]  funct3,
    input  logic [63:0] alu_result,
    input  logic [63:0] mem_rdata,
    input  logic [63:0] pc_plus4,
    output logic [63:0] WriteData,
    output logic [4:0]  RD,
    output logic        RegWrite,
    output logic        wb_valid,
    output logic [63:0] instret
);

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_LINK = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    logic [63:0] write_data_q, write_data_d;
    logic [4:0]  rd_q, rd_d;
    logic        reg_write_q, reg_write_d;
    logic        valid_q, valid_d;
    logic [63:0] instret_q, instret_d;

    logic [5:0]  lane_shamt;
    logic [63:0] lane_data;
    logic [63:0] load_data;
    logic [63:0] result;

    // Bring the addressed lane down to bit 0; unused low address bits are simply dropped.
    always_comb begin
        lane_shamt = 6'd0;
        case (funct3[1:0])
            2'b00:   lane_shamt = {alu_result[2:0], 3'b000};
            2'b01:   lane_shamt = {alu_result[2:1], 4'b0000};
            2'b10:   lane_shamt = {alu_result[2], 5'b00000};
            default: lane_shamt = 6'd0;
        endcase
        lane_data = mem_rdata >> lane_shamt;
    end

    always_comb begin
        load_data = lane_data;
        case (funct3)
            F3_LB:   load_data = {{56{lane_data[7]}},  lane_data[7:0]};
            F3_LH:   load_data = {{48{lane_data[15]}}, lane_data[15:0]};
            F3_LW:   load_data = {{32{lane_data[31]}}, lane_data[31:0]};
            F3_LBU:  load_data = {56'd0, lane_data[7:0]};
            F3_LHU:  load_data = {48'd0, lane_data[15:0]};
            F3_LWU:  load_data = {32'd0, lane_data[31:0]};
            default: load_data = lane_data;
        endcase
    end

    always_comb begin
        case (mem_to_reg)
            SEL_ALU:  result = alu_result;
            SEL_LOAD: result = load_data;
            SEL_LINK: result = pc_plus4;
            default:  result = 64'd0;
        endcase
    end

    // Flush beats stall; a bubble from MEM clears the write strobe but keeps the data/index.
    always_comb begin
        write_data_d = write_data_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        valid_d      = valid_q;
        instret_d    = instret_q;
        if (flush) begin
            reg_write_d = 1'b0;
            valid_d     = 1'b0;
        end else if (!stall) begin
            if (in_valid) begin
                write_data_d = result;
                rd_d         = in_rd;
                reg_write_d  = in_reg_write && (in_rd != 5'd0);
                valid_d      = 1'b1;
                instret_d    = instret_q + 64'd1;
            end else begin
                reg_write_d = 1'b0;
                valid_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_data_q <= 64'd0;
            rd_q         <= 5'd0;
            reg_write_q  <= 1'b0;
            valid_q      <= 1'b0;
            instret_q    <= INSTRET_INIT;
        end else begin
            write_data_q <= write_data_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            valid_q      <= valid_d;
            instret_q    <= instret_d;
        end
    end

    assign WriteData = write_data_q;
    assign RD        = rd_q;
    assign RegWrite  = reg_write_q;
    assign wb_valid  = valid_q;
    assign instret   = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed self-checking bench for wb_stage
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset, in_valid, stall, flush, in_reg_write;
    logic [4:0]  in_rd;
    logic [1:0]  mem_to_reg;
    logic [2:0]  funct3;
    logic [63:0] alu_result, mem_rdata, pc_plus4;
    logic [63:0] WriteData, instret, wd_w, ir_w;
    logic [4:0]  RD, rd_w;
    logic        RegWrite, wb_valid, rw_w, v_w;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_ir = 64'd0;
    logic [63:0] held_ir;

    wb_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .mem_to_reg(mem_to_reg), .funct3(funct3),
        .alu_result(alu_result), .mem_rdata(mem_rdata), .pc_plus4(pc_plus4),
        .WriteData(WriteData), .RD(RD), .RegWrite(RegWrite), .wb_valid(wb_valid), .instret(instret)
    );

    wb_stage #(.INSTRET_INIT(64'hFFFF_FFFF_FFFF_FFFE)) dut_w (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .mem_to_reg(mem_to_reg), .funct3(funct3),
        .alu_result(alu_result), .mem_rdata(mem_rdata), .pc_plus4(pc_plus4),
        .WriteData(wd_w), .RD(rd_w), .RegWrite(rw_w), .wb_valid(v_w), .instret(ir_w)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [63:0] alu, input logic [63:0] mem,
                         input logic [63:0] pc);
        in_valid = v; in_rd = rd; in_reg_write = rw; mem_to_reg = sel;
        funct3 = f3; alu_result = alu; mem_rdata = mem; pc_plus4 = pc;
    endtask

    // One load capture against the fixed doubleword 0x123456789ABCDEF0.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] exp);
        drive(1'b1, 5'd7, 1'b1, 2'b01, f3, addr, 64'h1234_5678_9ABC_DEF0, 64'h0);
        tick();
        exp_ir = exp_ir + 64'd1;
        check(tag, WriteData, exp);
        check({tag, "_rw"}, {63'd0, RegWrite}, 64'd1);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b1; flush = 1'b1;
        drive(1'b1, 5'd9, 1'b1, 2'b00, 3'b000, 64'h1234, 64'h0, 64'h0);
        tick();
        check("rst_wd", WriteData, 64'd0);
        check("rst_rd", {59'd0, RD}, 64'd0);
        check("rst_rw", {63'd0, RegWrite}, 64'd0);
        check("rst_valid", {63'd0, wb_valid}, 64'd0);
        check("rst_instret", instret, 64'd0);
        check("rst_instret_w", ir_w, 64'hFFFF_FFFF_FFFF_FFFE);
        reset = 1'b0; stall = 1'b0; flush = 1'b0;

        drive(1'b1, 5'd5, 1'b1, 2'b01, 3'b000, 64'h1003, 64'h0000_0000_8000_0000, 64'h0);
        tick();
        exp_ir = exp_ir + 64'd1;
        check("lb_wd", WriteData, 64'hFFFF_FFFF_FFFF_FF80);
        check("lb_rd", {59'd0, RD}, 64'd5);
        check("lb_rw", {63'd0, RegWrite}, 64'd1);
        check("lb_valid", {63'd0, wb_valid}, 64'd1);
        check("lb_instret", instret, exp_ir);
        funct3 = 3'b100;
        tick();
        exp_ir = exp_ir + 64'd1;
        check("lbu_wd", WriteData, 64'h80);

        // Output stays put when inputs move after the edge.
        #1 alu_result = 64'hDEAD; mem_to_reg = 2'b00;
        #1 check("no_comb_path", WriteData, 64'h80);

        do_load("lw_hi",  3'b010, 64'h4, 64'h0000_0000_1234_5678);
        do_load("lhu_1",  3'b101, 64'h2, 64'h0000_0000_0000_9ABC);
        do_load("lh_1",   3'b001, 64'h2, 64'hFFFF_FFFF_FFFF_9ABC);
        do_load("lw_lo",  3'b010, 64'h0, 64'hFFFF_FFFF_9ABC_DEF0);
        do_load("lwu_lo", 3'b110, 64'h0, 64'h0000_0000_9ABC_DEF0);
        do_load("ld",     3'b011, 64'h5, 64'h1234_5678_9ABC_DEF0);
        do_load("f3_111", 3'b111, 64'h3, 64'h1234_5678_9ABC_DEF0);
        do_load("lb_7",   3'b000, 64'h7, 64'h0000_0000_0000_0012);
        do_load("lbu_6",  3'b100, 64'h6, 64'h0000_0000_0000_0034);
        do_load("lb_1",   3'b000, 64'h1, 64'hFFFF_FFFF_FFFF_FFDE);
        do_load("lh_3",   3'b001, 64'h7, 64'h0000_0000_0000_1234);
        check("load_instret", instret, exp_ir);

        drive(1'b1, 5'd0, 1'b1, 2'b00, 3'b000, 64'd7, 64'h0, 64'h0);
        tick();
        exp_ir = exp_ir + 64'd1;
        check("x0_rw", {63'd0, RegWrite}, 64'd0);
        check("x0_valid", {63'd0, wb_valid}, 64'd1);
        check("x0_wd", WriteData, 64'd7);
        check("x0_instret", instret, exp_ir);

        drive(1'b1, 5'd12, 1'b0, 2'b00, 3'b000, 64'h1FF, 64'hFFFF, 64'h0);
        tick();
        exp_ir = exp_ir + 64'd1;
        check("nowrite_rw", {63'd0, RegWrite}, 64'd0);
        check("alu_f3_ignored", WriteData, 64'h1FF);

        drive(1'b1, 5'd3, 1'b1, 2'b00, 3'b001, 64'h55, 64'h0, 64'h0);
        tick();
        exp_ir = exp_ir + 64'd1;
        check("cap55_wd", WriteData, 64'h55);
        held_ir = exp_ir;
        stall = 1'b1;
        drive(1'b1, 5'd9, 1'b1, 2'b00, 3'b000, 64'hAA, 64'h0, 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_wd", WriteData, 64'h55);
            check("stall_rd", {59'd0, RD}, 64'd3);
            check("stall_rw", {63'd0, RegWrite}, 64'd1);
            check("stall_instret", instret, held_ir);
        end
        flush = 1'b1;
        tick();
        check("flush_rw", {63'd0, RegWrite}, 64'd0);
        check("flush_valid", {63'd0, wb_valid}, 64'd0);
        check("flush_wd", WriteData, 64'h55);
        check("flush_rd", {59'd0, RD}, 64'd3);
        check("flush_instret", instret, held_ir);
        stall = 1'b0; flush = 1'b0;

        drive(1'b1, 5'd1, 1'b1, 2'b10, 3'b000, 64'h77, 64'h0, 64'h104);
        tick();
        exp_ir = exp_ir + 64'd1;
        check("link_wd", WriteData, 64'h104);
        check("link_rw", {63'd0, RegWrite}, 64'd1);
        mem_to_reg = 2'b11;
        tick();
        exp_ir = exp_ir + 64'd1;
        check("zero_wd", WriteData, 64'd0);

        drive(1'b0, 5'd20, 1'b1, 2'b00, 3'b000, 64'h999, 64'h0, 64'h0);
        tick();
        check("bubble_valid", {63'd0, wb_valid}, 64'd0);
        check("bubble_rw", {63'd0, RegWrite}, 64'd0);
        check("bubble_rd", {59'd0, RD}, 64'd1);
        check("bubble_instret", instret, exp_ir);

        drive(1'b1, 5'd8, 1'b1, 2'b00, 3'b000, 64'h31, 64'h0, 64'h0);
        tick();
        check("cap31_rw", {63'd0, RegWrite}, 64'd1);
        stall = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        check("rst_stall_wd", WriteData, 64'd0);
        check("rst_stall_rd", {59'd0, RD}, 64'd0);
        check("rst_stall_rw", {63'd0, RegWrite}, 64'd0);
        check("rst_stall_valid", {63'd0, wb_valid}, 64'd0);
        check("rst_stall_instret", instret, 64'd0);
        reset = 1'b0; stall = 1'b0;
        drive(1'b1, 5'd4, 1'b1, 2'b00, 3'b000, 64'd9, 64'h0, 64'h0);
        tick();
        check("post_rst_wd", WriteData, 64'd9);
        check("post_rst_rd", {59'd0, RD}, 64'd4);
        check("post_rst_instret", instret, 64'd1);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("wrap_start", ir_w, 64'hFFFF_FFFF_FFFF_FFFE);
        tick();
        check("wrap_max", ir_w, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        check("wrap_zero", ir_w, 64'd0);
        check("wrap_main", instret, 64'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
